npu_alu: RTL
============

NPU_ALU -- requirements
Module: npu_alu

Interface
REQ-001 SHALL have parameter: DEPTH, 1024, number of elements processed per run (the local-memory length).
REQ-002 SHALL have port: CLK  input  1  single clock; all flops on rising edge.
REQ-003 SHALL have port: RESET_X  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: SOFT_RESET  input  1  CPU soft reset; internal reset = RESET_X AND NOT SOFT_RESET, asynchronous.
REQ-005 SHALL have port: NPU_EN  input  1  operand-valid strobe from the local memory controller.
REQ-006 SHALL have port: A_RDATA  input  8  operand A, signed two's complement.
REQ-007 SHALL have port: B_RDATA  input  8  operand B, signed two's complement.
REQ-008 SHALL have port: OPCODE  input  3  operation select, CPU register.
REQ-009 SHALL have port: SHIFT  input  3  arithmetic right shift applied to MUL product.
REQ-010 SHALL have port: LM_EN  output  1  result-valid strobe to the local memory controller.
REQ-011 SHALL have port: C_WDATA  output  8  result, signed.
REQ-012 SHALL have port: BUSY  output  1  high while a run is in progress.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-014 IDLE->RUN on NPU_EN=1; OPCODE and SHIFT latched that cycle and held for the whole run.
REQ-015 In RUN, each cycle with NPU_EN=1 accepts one (A,B) pair and increments 11-bit accept counter.
REQ-016 RUN->DRAIN when accept counter reaches DEPTH; NPU_EN pairs beyond DEPTH ignored.
REQ-017 NPU_EN low inside RUN is a bubble: no accept, no LM_EN for that slot, state stays RUN.
REQ-018 Fixed 3-cycle pipeline: pair accepted at edge t yields LM_EN=1 with its C_WDATA in cycle t+3; LM_EN is a one-cycle pulse per element.
REQ-019 DRAIN->DONE when the emit counter reaches DEPTH; exactly DEPTH LM_EN pulses per run.
REQ-020 DONE->IDLE when NPU_EN=0; while in DONE with NPU_EN=1 no new run starts.
REQ-021 BUSY=1 in RUN and DRAIN, else 0.
REQ-022 Ops: 000 A+B; 001 A-B; 010 (A*B)>>>SHIFT; 011 max(A,B); 100 min(A,B); 101 relu(A); 110 A; 111 B.
REQ-023 Arithmetic SHALL be signed at full width (9-bit add/sub, 16-bit product) before final narrowing to 8 bits.
REQ-024 Stage 1 registers operands; stage 2 computes full-width result; stage 3 applies shift and narrowing into C_WDATA.
REQ-025 C_WDATA SHALL hold its last value when LM_EN=0.

Reset
REQ-026 On internal reset: state IDLE, counters 0, pipeline valids 0, LM_EN=0, C_WDATA=0, BUSY=0, latched OPCODE/SHIFT=0.
REQ-027 Reset asserted mid-run SHALL abort immediately; in-flight elements are discarded and no LM_EN follows release.
REQ-028 After reset release the block SHALL accept a new run on the next NPU_EN=1.

Configuration
REQ-029 Macro NPU_ALU_SAT_EN defined: narrowing saturates to [-128,127] for every op.
REQ-030 Macro NPU_ALU_SAT_EN undefined: narrowing takes the low 8 bits (wrap-around); no saturation logic is compiled in.

Verification
REQ-031 ADD: A=100, B=50, NPU_EN high for 1024 cycles -> 1024 LM_EN pulses, C_WDATA=127 with SAT_EN, -106 without.
REQ-032 MUL: A=-64, B=64, SHIFT=6 -> C_WDATA=-64, first LM_EN exactly 3 cycles after first accept.
REQ-033 Bubbles: NPU_EN toggles 1,0,1,0 over the run -> LM_EN pattern matches with 3-cycle delay; total exactly 1024 pulses; BUSY falls after the last pulse.
REQ-034 Overrun: NPU_EN held high 1100 cycles, OPCODE changed mid-run -> exactly 1024 pulses, all computed with the start-latched OPCODE, no restart until NPU_EN drops.
REQ-035 SOFT_RESET pulse at element 500 -> LM_EN, C_WDATA, BUSY go 0 at once; next NPU_EN starts a fresh 1024-element run.
REQ-036 RELU/MAX/MIN: A=-5, B=3 -> 0 / 3 / -5.

Source files
------------

// File: rtl/npu_alu.sv
// npu_alu: streaming element-wise ALU between the local memory read and write ports.
// A run accepts DEPTH operand pairs and emits exactly DEPTH results through a fixed
// three-stage pipeline.
// Optional feature: define NPU_ALU_SAT_EN to saturate results to [-128,127]; otherwise
// results wrap to their low 8 bits.
module npu_alu #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic       CLK,
  input  logic       RESET_X,
  input  logic       SOFT_RESET,
  input  logic       NPU_EN,
  input  logic [7:0] A_RDATA,
  input  logic [7:0] B_RDATA,
  input  logic [2:0] OPCODE,
  input  logic [2:0] SHIFT,
  output logic       LM_EN,
  output logic [7:0] C_WDATA,
  output logic       BUSY
);

  localparam logic [10:0] LastCnt = 11'(DEPTH);

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpMul  = 3'b010;
  localparam logic [2:0] OpMax  = 3'b011;
  localparam logic [2:0] OpMin  = 3'b100;
  localparam logic [2:0] OpRelu = 3'b101;
  localparam logic [2:0] OpA    = 3'b110;
  localparam logic [2:0] OpB    = 3'b111;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  // Soft reset is folded into the asynchronous reset so a CPU abort takes effect at once.
  logic rst_n;
  assign rst_n = RESET_X & ~SOFT_RESET;

  state_e             state_q, state_d;
  logic [10:0]        acc_cnt_q, acc_cnt_d;
  logic [10:0]        emit_cnt_q, emit_cnt_d;
  logic [2:0]         op_q, op_d;
  logic [2:0]         shift_q, shift_d;
  logic               accept;

  logic               v1_q, v2_q, lm_en_q;
  logic signed [7:0]  a1_q, b1_q;
  logic signed [15:0] a_ext, b_ext;
  logic signed [15:0] r2_q, r2_d;
  logic signed [7:0]  c_q;
  logic signed [7:0]  narrowed;

  // Run control: start, accept counting, drain and the wait for NPU_EN to drop.
  always_comb begin
    state_d    = state_q;
    acc_cnt_d  = acc_cnt_q;
    emit_cnt_d = emit_cnt_q;
    op_d       = op_q;
    shift_d    = shift_q;
    accept     = 1'b0;
    if (v2_q) begin
      emit_cnt_d = emit_cnt_q + 11'd1;
    end
    unique case (state_q)
      StIdle: begin
        if (NPU_EN) begin
          // The starting beat is itself the first element of the run.
          accept    = 1'b1;
          op_d      = OPCODE;
          shift_d   = SHIFT;
          acc_cnt_d = 11'd1;
          state_d   = (LastCnt == 11'd1) ? StDrain : StRun;
        end
      end
      StRun: begin
        if (NPU_EN) begin
          accept    = 1'b1;
          acc_cnt_d = acc_cnt_q + 11'd1;
          if (acc_cnt_q + 11'd1 == LastCnt) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // emit_cnt_q reaches DEPTH during the cycle of the final LM_EN pulse.
        if (emit_cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (!NPU_EN) begin
          state_d    = StIdle;
          acc_cnt_d  = '0;
          emit_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      acc_cnt_q  <= '0;
      emit_cnt_q <= '0;
      op_q       <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      acc_cnt_q  <= acc_cnt_d;
      emit_cnt_q <= emit_cnt_d;
      op_q       <= op_d;
      shift_q    <= shift_d;
    end
  end

  assign a_ext = {{8{a1_q[7]}}, a1_q};
  assign b_ext = {{8{b1_q[7]}}, b1_q};

  // Stage 2 datapath: full-width signed result before any narrowing.
  always_comb begin
    r2_d = '0;
    unique case (op_q)
      OpAdd:   r2_d = a_ext + b_ext;
      OpSub:   r2_d = a_ext - b_ext;
      OpMul:   r2_d = a_ext * b_ext;
      OpMax:   r2_d = (a1_q > b1_q) ? a_ext : b_ext;
      OpMin:   r2_d = (a1_q < b1_q) ? a_ext : b_ext;
      OpRelu:  r2_d = a1_q[7] ? 16'sd0 : a_ext;
      OpA:     r2_d = a_ext;
      OpB:     r2_d = b_ext;
      default: r2_d = '0;
    endcase
  end

`ifdef NPU_ALU_SAT_EN
  logic signed [15:0] shifted;
  assign shifted = (op_q == OpMul) ? (r2_q >>> shift_q) : r2_q;

  // Stage 3 narrowing: clamp to the signed 8-bit range.
  always_comb begin
    narrowed = shifted[7:0];
    if (shifted > 16'sd127) begin
      narrowed = 8'sd127;
    end else if (shifted < -16'sd128) begin
      narrowed = -8'sd128;
    end
  end
`else
  // Stage 3 narrowing: plain wrap-around to the low byte.
  always_comb begin
    narrowed = 8'((op_q == OpMul) ? (r2_q >>> shift_q) : r2_q);
  end
`endif

  // Three-stage pipeline: operands, full-width result, narrowed output.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      lm_en_q <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      r2_q    <= '0;
      c_q     <= '0;
    end else begin
      v1_q    <= accept;
      v2_q    <= v1_q;
      lm_en_q <= v2_q;
      if (accept) begin
        a1_q <= A_RDATA;
        b1_q <= B_RDATA;
      end
      if (v1_q) begin
        r2_q <= r2_d;
      end
      // Output data only moves with a valid element, so it holds between pulses.
      if (v2_q) begin
        c_q <= narrowed;
      end
    end
  end

  assign LM_EN   = lm_en_q;
  assign C_WDATA = c_q;
  assign BUSY    = (state_q == StRun) || (state_q == StDrain);

endmodule
